pong_game_ctrl: RTL and testbench

Sequencing controller for the pong datapath: owns the ball position and direction registers, advances the ball once per frame tick, and reacts to the paddle/floor contact flags produced by the collision-detection block. Maintains score and lives and runs the serve / play / miss / game-over state machine. Sits between the frame timing generator and the renderer; its `ball_x`/`ball_y` outputs drive both the collision detector and the display.

---
 rtl/pong_pkg.sv | 15 +
 rtl/pong_game_ctrl_ball_motion.sv | 79 +++++++
 rtl/pong_game_ctrl.sv | 123 ++++++++++++
 tb/tb_pong_game_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared state encoding and direction constants for the pong controller.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } game_state_t;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/pong_game_ctrl_ball_motion.sv
// Ball position/direction registers with wall and ceiling reflection.
module ball_motion
  import pong_pkg::*;
#(
  parameter int BIT_WIDTH = 10,
  parameter int START_X   = 320,
  parameter int START_Y   = 240,
  parameter int X_MIN     = 8,
  parameter int X_MAX     = 631,
  parameter int CEIL_Y    = 471
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step_i,
  input  logic                 reload_i,
  input  logic                 paddle_rev_i,
  output logic [BIT_WIDTH-1:0] ball_x_o,
  output logic [BIT_WIDTH-1:0] ball_y_o
);

  localparam logic [BIT_WIDTH-1:0] StartX = BIT_WIDTH'(START_X);
  localparam logic [BIT_WIDTH-1:0] StartY = BIT_WIDTH'(START_Y);
  localparam logic [BIT_WIDTH-1:0] XMin   = BIT_WIDTH'(X_MIN);
  localparam logic [BIT_WIDTH-1:0] XMax   = BIT_WIDTH'(X_MAX);
  localparam logic [BIT_WIDTH-1:0] CeilY  = BIT_WIDTH'(CEIL_Y);
  localparam logic [BIT_WIDTH-1:0] One    = BIT_WIDTH'(1);

  logic [BIT_WIDTH-1:0] ballX_q, ballX_d, ballY_q, ballY_d;
  logic                 dirX_q, dirX_d, dirY_q, dirY_d;
  logic                 dirXNew, dirYNew;

  // A paddle hit already reverses X, so the wall test is skipped to avoid a double flip.
  always_comb begin
    ballX_d = ballX_q;
    ballY_d = ballY_q;
    dirX_d  = dirX_q;
    dirY_d  = dirY_q;
    dirXNew = dirX_q;
    dirYNew = dirY_q;
    if (reload_i) begin
      ballX_d = StartX;
      ballY_d = StartY;
      dirX_d  = DIR_POS;
      dirY_d  = DIR_POS;
    end else if (step_i) begin
      if (paddle_rev_i) begin
        dirXNew = ~dirX_q;
      end else if ((dirX_q == DIR_POS && ballX_q >= XMax) ||
                   (dirX_q == DIR_NEG && ballX_q <= XMin)) begin
        dirXNew = ~dirX_q;
      end
      if (dirY_q == DIR_POS && ballY_q >= CeilY) begin
        dirYNew = ~dirY_q;
      end
      ballX_d = (dirXNew == DIR_POS) ? ballX_q + One : ballX_q - One;
      ballY_d = (dirYNew == DIR_POS) ? ballY_q + One : ballY_q - One;
      dirX_d  = dirXNew;
      dirY_d  = dirYNew;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ballX_q <= StartX;
      ballY_q <= StartY;
      dirX_q  <= DIR_POS;
      dirY_q  <= DIR_POS;
    end else begin
      ballX_q <= ballX_d;
      ballY_q <= ballY_d;
      dirX_q  <= dirX_d;
      dirY_q  <= dirY_d;
    end
  end

  assign ball_x_o = ballX_q;
  assign ball_y_o = ballY_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Game sequencing: serve/play/miss/over FSM, score, lives and miss-delay counter.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BIT_WIDTH  = 10,
  parameter int START_X    = 320,
  parameter int START_Y    = 240,
  parameter int X_MIN      = 8,
  parameter int X_MAX      = 631,
  parameter int CEIL_Y     = 471,
  parameter int LIVES_INIT = 3,
  parameter int MISS_TICKS = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 start,
  input  logic                 touching_paddle,
  input  logic                 touching_floor,
  output logic [BIT_WIDTH-1:0] ball_x,
  output logic [BIT_WIDTH-1:0] ball_y,
  output logic [7:0]           score,
  output logic [2:0]           lives,
  output logic [2:0]           state,
  output logic                 game_over
);

  localparam int              MissW     = (MISS_TICKS > 1) ? $clog2(MISS_TICKS) : 1;
  localparam logic [MissW-1:0] MissLast = MissW'(MISS_TICKS - 1);
  localparam logic [2:0]      LivesInit = 3'(LIVES_INIT);

  game_state_t      state_q, state_d;
  logic [7:0]       score_q, score_d;
  logic [2:0]       lives_q, lives_d;
  logic [MissW-1:0] missCnt_q, missCnt_d;
  logic             gameOver_q;
  logic             stepEn, reloadBall, paddleRev;

  // Next-state and counter updates; entering IDLE always restarts the game totals.
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    lives_d   = lives_q;
    missCnt_d = missCnt_q;
    stepEn    = 1'b0;
    paddleRev = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = SERVE;
      SERVE: if (start) state_d = PLAY;
      PLAY: begin
        if (frame_tick) begin
          if (touching_floor) begin
            if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
            missCnt_d = '0;
            state_d   = MISS;
          end else begin
            stepEn = 1'b1;
            if (touching_paddle) begin
              paddleRev = 1'b1;
              if (score_q != 8'hFF) score_d = score_q + 8'd1;
            end
          end
        end
      end
      MISS: begin
        if (frame_tick) begin
          if (missCnt_q == MissLast) begin
            missCnt_d = '0;
            state_d   = (lives_q == 3'd0) ? OVER : SERVE;
          end else begin
            missCnt_d = missCnt_q + 1'b1;
          end
        end
      end
      OVER:    if (start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      score_d = 8'd0;
      lives_d = LivesInit;
    end
    reloadBall = (state_d == IDLE) || (state_d == SERVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      score_q    <= 8'd0;
      lives_q    <= LivesInit;
      missCnt_q  <= '0;
      gameOver_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      missCnt_q  <= missCnt_d;
      gameOver_q <= (state_d == OVER);
    end
  end

  ball_motion #(
    .BIT_WIDTH(BIT_WIDTH),
    .START_X  (START_X),
    .START_Y  (START_Y),
    .X_MIN    (X_MIN),
    .X_MAX    (X_MAX),
    .CEIL_Y   (CEIL_Y)
  ) u_ball (
    .clk         (clk),
    .reset       (reset),
    .step_i      (stepEn),
    .reload_i    (reloadBall),
    .paddle_rev_i(paddleRev),
    .ball_x_o    (ball_x),
    .ball_y_o    (ball_y)
  );

  assign score     = score_q;
  assign lives     = lives_q;
  assign state     = state_q;
  assign game_over = gameOver_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: vector table, corner sequences and random play against a reference model.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  localparam int StartX    = 320;
  localparam int StartY    = 240;
  localparam int XMin      = 8;
  localparam int XMax      = 631;
  localparam int CeilY     = 471;
  localparam int LivesInit = 3;
  localparam int MissTicks = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       touching_paddle = 1'b0;
  logic       touching_floor = 1'b0;
  logic [9:0] ball_x, ball_y;
  logic [7:0] score;
  logic [2:0] lives, state;
  logic       game_over;

  int testsRun = 0;
  int testsFailed = 0;

  int mX, mY, mDx, mDy, mScore, mLives, mMiss;
  game_state_t mState;

  typedef struct {
    bit st, tk, pad, fl;
    int ex, ey, es, el, est;
  } vec_t;
  vec_t vecs[13];

  pong_game_ctrl #(
    .BIT_WIDTH(10), .START_X(StartX), .START_Y(StartY), .X_MIN(XMin),
    .X_MAX(XMax), .CEIL_Y(CeilY), .LIVES_INIT(LivesInit), .MISS_TICKS(MissTicks)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .touching_paddle(touching_paddle), .touching_floor(touching_floor),
    .ball_x(ball_x), .ball_y(ball_y), .score(score), .lives(lives),
    .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic modelServe();
    mX = StartX; mY = StartY; mDx = 1; mDy = 1;
  endtask

  task automatic modelReset();
    modelServe();
    mScore = 0; mLives = LivesInit; mMiss = 0; mState = IDLE;
  endtask

  // Game rules in plain integer arithmetic, one call per clock edge.
  task automatic modelStep(input bit st, input bit tk, input bit pad, input bit fl);
    case (mState)
      IDLE:  if (st) begin mState = SERVE; modelServe(); end
      SERVE: if (st) mState = PLAY;
      PLAY: if (tk) begin
        if (fl) begin
          if (mLives > 0) mLives--;
          mMiss = 0;
          mState = MISS;
        end else begin
          if (pad) begin
            mDx = -mDx;
            mScore = (mScore < 255) ? mScore + 1 : 255;
          end else if (mX + mDx < XMin || mX + mDx > XMax) begin
            mDx = -mDx;
          end
          if (mY + mDy > CeilY) mDy = -mDy;
          mX = (mX + mDx + 1024) % 1024;
          mY = (mY + mDy + 1024) % 1024;
        end
      end
      MISS: if (tk) begin
        mMiss++;
        if (mMiss == MissTicks) begin
          mMiss = 0;
          if (mLives == 0) mState = OVER;
          else begin mState = SERVE; modelServe(); end
        end
      end
      OVER: if (st) begin
        mState = IDLE; mScore = 0; mLives = LivesInit; modelServe();
      end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input bit st, input bit tk, input bit pad, input bit fl);
    start = st; frame_tick = tk; touching_paddle = pad; touching_floor = fl;
    @(posedge clk);
    modelStep(st, tk, pad, fl);
    #1;
    start = 1'b0; frame_tick = 1'b0; touching_paddle = 1'b0; touching_floor = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    @(posedge clk);
    modelReset();
    #1;
    reset = 1'b0;
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input int ex, input int ey, input int es,
                             input int el, input int est);
    checkValue({name, ".ball_x"}, int'(ball_x), ex);
    checkValue({name, ".ball_y"}, int'(ball_y), ey);
    checkValue({name, ".score"}, int'(score), es);
    checkValue({name, ".lives"}, int'(lives), el);
    checkValue({name, ".state"}, int'(state), est);
    checkValue({name, ".game_over"}, int'(game_over), (est == int'(OVER)) ? 1 : 0);
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, mX, mY, mScore, mLives, int'(mState));
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 320, 240, 0, 3, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 320, 240, 0, 3, 1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 320, 240, 0, 3, 1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 320, 240, 0, 3, 2};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 321, 241, 0, 3, 2};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 321, 241, 0, 3, 2};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 322, 242, 0, 3, 2};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 323, 243, 0, 3, 2};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 322, 244, 1, 3, 2};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 321, 245, 1, 3, 2};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 321, 245, 1, 2, 3};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 321, 245, 1, 2, 3};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 321, 245, 1, 2, 3};

    applyReset();
    checkOutput("reset", StartX, StartY, 0, LivesInit, int'(IDLE));
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].st, vecs[i].tk, vecs[i].pad, vecs[i].fl);
      checkOutput($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].es,
                  vecs[i].el, vecs[i].est);
    end

    // Miss delay: still MISS after 59 ticks, re-serve on the 60th with direction reset.
    for (int i = 0; i < MissTicks - 1; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("miss59", 321, 245, 1, 2, int'(MISS));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("miss60", 320, 240, 1, 2, int'(SERVE));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("reserve_move", 321, 241, 1, 2, int'(PLAY));

    // Right wall and ceiling reflection.
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 311; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      if (i % 50 == 0 || i == 231 || i == 232) checkModel($sformatf("wall%0d", i));
    end
    checkOutput("at_wall", 631, 391, 0, 3, int'(PLAY));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("wall_bounce", 630, 390, 0, 3, int'(PLAY));

    // Score saturation with a paddle contact on every tick.
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 254; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("score254", 320, 448, 254, 3, int'(PLAY));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("score255", 319, 447, 255, 3, int'(PLAY));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("score_sat", 320, 446, 255, 3, int'(PLAY));

    // Three floor hits to game over, then restart.
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("floor%0d", k), 321, 241, 0, 2 - k, int'(MISS));
      for (int i = 0; i < MissTicks; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("over", 321, 241, 0, 0, int'(OVER));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("over_hold", 321, 241, 0, 0, int'(OVER));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("restart", 320, 240, 0, 3, int'(IDLE));

    // Reset in the middle of play.
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) applyStimulus(1'b0, 1'b1, (i % 10) == 3, 1'b0);
    checkModel("pre_reset");
    applyReset();
    checkOutput("mid_reset", 320, 240, 0, 3, int'(IDLE));

    // Random play compared cycle by cycle against the model.
    applyReset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        applyReset();
      end else begin
        applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 7) == 0,
                      ($urandom_range(0, 39) == 0) || (mY < 20));
      end
      checkModel("rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
